mips_avalon_arbiter: RTL

Two-master, one-slave Avalon memory-mapped arbiter that shares a single memory slave (e.g. the test RAM at 0xBFC00000) between the CPU instruction-fetch port (master 0) and data port (master 1). It sits between the MIPS core's two bus ports and the memory slave. It grants one whole transaction at a time, holds the grant until the slave completes, and stalls the losing master with `waitrequest`.

---
 rtl/mips_bus_pkg.sv | 18 +
 rtl/mips_arb_pick.sv | 35 +++
 rtl/mips_avalon_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS Avalon bus slice.
//   arb_state_t     : arbiter FSM states; the encoding doubles as the one-hot
//                     grant vector (bit0 = m0, bit1 = m1, 0 = idle).
//   ARB_NUM_MASTERS : number of masters sharing the slave.
//   DEF_ADDR_W/DEF_DATA_W : default bus widths.
package mips_bus_pkg;

  localparam int ARB_NUM_MASTERS = 2;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mips_arb_pick.sv
// Combinational tie-break for the two-master arbiter.
//   req[1:0]   : in  request vector (bit0 = m0, bit1 = m1)
//   last_owner : in  master that completed the most recent transaction
//   winner     : out selected master (0 = m0, 1 = m1); don't care when req == 0
// Build option: MIPS_ARB_ROUND_ROBIN_EN defined -> ties go to the master that
// is not last_owner; undefined -> m1 (data port) always wins ties.
module mips_arb_pick
  import mips_bus_pkg::*;
(
  input  logic [ARB_NUM_MASTERS-1:0] req,
  input  logic                       last_owner,
  output logic                       winner
);

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = 1'b0;
    if (req[1] && !req[0])
      winner = 1'b1;
    else if (req[0] && req[1])
      winner = ~last_owner;
  end
`else
  // Fixed priority never consults last_owner.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    winner = 1'b0;
    if (req[1])
      winner = 1'b1;
  end
`endif

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Two-master / one-slave Avalon-MM arbiter: instruction fetch (m0) and data
// (m1) ports of the MIPS core share a single memory slave. One whole
// transaction is granted at a time; the losing master is stalled with
// waitrequest, and an idle cycle always separates two grants so the slave
// sees its strobes drop.
// Ports:
//   clk, rst (asynchronous, active-low)
//   m0_*/m1_* : master-side address/read/write/writedata/byteenable in,
//               waitrequest/readdata out
//   s_*       : slave-side address/read/write/writedata/byteenable out,
//               waitrequest/readdata in
//   grant     : registered one-hot owner (bit0 = m0, bit1 = m1), 0 when idle
// Build option: MIPS_ARB_ROUND_ROBIN_EN selects round-robin tie-break
// (see mips_arb_pick); default is fixed priority to m1.
module mips_avalon_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant
);

  arb_state_t                 state;
  logic                       last_owner;
  logic [ARB_NUM_MASTERS-1:0] req;
  logic                       winner;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  mips_arb_pick u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  // The state encoding is the grant vector, so grant is a register output.
  assign grant = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|req)
            state <= winner ? OWN1 : OWN0;
        end
        OWN0: begin
          // A dropped request abandons the grant without crediting m0.
          if (!req[0]) begin
            state <= IDLE;
          end else if (!s_waitrequest) begin
            state      <= IDLE;
            last_owner <= 1'b0;
          end
        end
        OWN1: begin
          if (!req[1]) begin
            state <= IDLE;
          end else if (!s_waitrequest) begin
            state      <= IDLE;
            last_owner <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = req[0];
    m1_waitrequest = req[1];
    case (state)
      OWN0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      OWN1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule
